// File: rtl/coin_return_engine_if.sv
// rtl/coin_return_engine_if.sv - parent/engine bus for the coin return engine
interface coin_return_engine_if #(
  parameter int NUM_COINS  = 3,
  parameter int TOTAL_BITS = 31,
  parameter int WAIT_BITS  = 8
);
  logic [TOTAL_BITS-1:0] i_total;
  logic                  i_trigger_return;
  logic                  i_activity;
  logic [NUM_COINS-1:0]  i_coin_empty;
  logic [NUM_COINS-1:0]  o_return_coin;
  logic [TOTAL_BITS-1:0] o_coin_value;
  logic                  o_busy;
  logic                  o_done;
  logic [TOTAL_BITS-1:0] o_residue;
  logic [WAIT_BITS-1:0]  o_wait_time;

  // Parent side: supplies balance and user events, consumes the coin stream.
  modport master (
    output i_total, i_trigger_return, i_activity, i_coin_empty,
    input  o_return_coin, o_coin_value, o_busy, o_done, o_residue, o_wait_time
  );

  // Engine side.
  modport slave (
    input  i_total, i_trigger_return, i_activity, i_coin_empty,
    output o_return_coin, o_coin_value, o_busy, o_done, o_residue, o_wait_time
  );
endinterface

// File: rtl/coin_return_engine.sv
// rtl/coin_return_engine.sv - idle timer plus greedy largest-first coin dispenser
module coin_return_engine #(
  parameter int                            NUM_COINS   = 3,
  parameter int                            VAL_BITS    = 16,
  parameter logic [NUM_COINS*VAL_BITS-1:0] COIN_VALUES = {16'd1000, 16'd500, 16'd100},
  parameter int                            TOTAL_BITS  = 31,
  parameter int                            WAIT_BITS   = 8,
  parameter int                            WAIT_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 reset_n,
  coin_return_engine_if.slave  bus
);

  localparam logic [WAIT_BITS-1:0] WAIT_RELOAD = WAIT_BITS'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPENSE,
    ST_DONE
  } state_t;

  state_t                state;
  logic [TOTAL_BITS-1:0] remain;
  logic [WAIT_BITS-1:0]  timer;
  logic                  busy_q;
  logic                  done_q;
  logic [TOTAL_BITS-1:0] residue_q;

  logic [TOTAL_BITS-1:0] coin_val [NUM_COINS];
  logic [NUM_COINS-1:0]  sel_onehot;
  logic [TOTAL_BITS-1:0] sel_value;
  logic                  sel_found;
  logic                  timeout_fire;
  logic                  start;

  // Denomination values widened to balance width so comparisons are unsigned and same-sized.
  for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin_val
    assign coin_val[g] = TOTAL_BITS'(COIN_VALUES[g*VAL_BITS +: VAL_BITS]);
  end

  // Pick the largest stocked denomination that still fits in the remaining balance;
  // scanning upward lets each larger eligible coin override the previous pick.
  always_comb begin
    sel_onehot = '0;
    sel_value  = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (!bus.i_coin_empty[i] && (coin_val[i] <= remain)) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_value     = coin_val[i];
      end
    end
    sel_found = |sel_onehot;
  end

  // Auto-return fires only when the timer has run out on a non-zero balance with no fresh activity.
  always_comb begin
    timeout_fire = (timer == '0) && (bus.i_total != '0) && !bus.i_activity;
    start        = bus.i_trigger_return || timeout_fire;
  end

  assign bus.o_return_coin = (state == ST_DISPENSE) ? sel_onehot : '0;
  assign bus.o_coin_value  = (state == ST_DISPENSE) ? sel_value  : '0;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_residue     = residue_q;
  assign bus.o_wait_time   = timer;

  // Main FSM: idle timing, one coin per DISPENSE cycle, single-cycle DONE pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      remain    <= '0;
      timer     <= WAIT_RELOAD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      residue_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            timer  <= WAIT_RELOAD;
            busy_q <= 1'b1;
            remain <= bus.i_total;
            if (bus.i_total != '0) begin
              state <= ST_DISPENSE;
            end else begin
              // Nothing to hand back: report completion straight away.
              state     <= ST_DONE;
              done_q    <= 1'b1;
              residue_q <= '0;
            end
          end else if (bus.i_activity) begin
            timer <= WAIT_RELOAD;
          end else if ((bus.i_total != '0) && (timer != '0)) begin
            timer <= timer - WAIT_BITS'(1);
          end
        end

        ST_DISPENSE: begin
          if (sel_found) begin
            remain <= remain - sel_value;
          end else begin
            state     <= ST_DONE;
            done_q    <= 1'b1;
            residue_q <= remain;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          timer  <= WAIT_RELOAD;
        end

        default: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/coin_return_engine.md
Name: coin_return_engine

Overview:
- Sequential change-return engine for the vending machine datapath.
- Holds an idle-timeout counter and, on a return request or timeout, dispenses the balance as a stream of coins, one per cycle, greedy largest-first.
- Denomination count and values are parametrised. Empty coin tubes are skipped.
- The parent deducts each emitted coin's value from its balance register.

Parameters:
- NUM_COINS, 3, number of coin denominations; index 0 is the smallest.
- VAL_BITS, 16, width of each denomination value.
- COIN_VALUES, {16'd1000,16'd500,16'd100}, packed values; denomination i at [i*VAL_BITS +: VAL_BITS]; strictly ascending with index.
- TOTAL_BITS, 31, width of the balance.
- WAIT_BITS, 8, width of the timeout counter.
- WAIT_CYCLES, 100, idle cycles before auto-return; must be ≥1 and < 2^WAIT_BITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_total  in  TOTAL_BITS  current balance from the parent, unsigned.
- i_trigger_return  in  1  return button, level-sampled.
- i_activity  in  1  coin insert or item select this cycle; reloads the timer.
- i_coin_empty  in  NUM_COINS  bit i=1: denomination i unavailable.
- o_return_coin  out  NUM_COINS  one-hot coin emitted this cycle, or all zero.
- o_coin_value  out  TOTAL_BITS  value of the emitted coin, zero-extended; 0 when none.
- o_busy  out  1  high in DISPENSE and DONE.
- o_done  out  1  one-cycle pulse at the end of a return.
- o_residue  out  TOTAL_BITS  amount not returnable at the last DONE; held until the next start.
- o_wait_time  out  WAIT_BITS  remaining timeout count.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, remain=0, timer=WAIT_CYCLES.
  - o_return_coin=0, o_coin_value=0, o_busy=0, o_done=0, o_residue=0.
  - Reset mid-dispense aborts immediately; no further coins are emitted.
- States: IDLE, DISPENSE, DONE.
- IDLE, timer update, in priority order:
  - i_activity=1 → timer=WAIT_CYCLES.
  - else if i_total≠0 and timer≠0 → timer-1.
  - else hold.
- IDLE, start condition: i_trigger_return=1, or (timer==0 and i_total≠0 and i_activity=0).
  - Start with i_total≠0 → remain=i_total, go to DISPENSE.
  - Start with i_total==0 (trigger only) → go straight to DONE with remain=0.
  - Trigger takes priority over activity in the same cycle; the timer is reloaded on start.
- DISPENSE, each cycle (combinational select on registered remain):
  - k = highest index with COIN_VALUES[k] ≤ remain (unsigned, zero-extended) and i_coin_empty[k]=0.
  - If k exists: o_return_coin=1<<k, o_coin_value=COIN_VALUES[k], remain -= value at the edge.
  - If none exists: no coin this cycle, go to DONE.
  - Latency: N coins occupy N+1 DISPENSE cycles, then one DONE cycle.
- i_coin_empty is sampled every DISPENSE cycle; a mid-return change takes effect on the next selection.
- i_trigger_return, i_activity and i_total are ignored in DISPENSE and DONE.
- DONE (one cycle):
  - o_done=1, o_busy=1; o_residue=remain, captured on entry and held.
  - Timer=WAIT_CYCLES; go to IDLE.
- Outputs o_return_coin and o_coin_value are combinational from state, remain and i_coin_empty. All others are registered.
- Remain never underflows, because selection requires value ≤ remain.

Test Plan:
1. Reset, i_total=1600, pulse trigger → coins 100b(1000), 010b(500), 001b(100) on consecutive cycles, then one empty cycle, then o_done with o_residue=0; o_busy high 5 cycles.
2. i_total=1600, i_coin_empty=100b, trigger → 500, 500, 500, 100, then done, o_residue=0.
3. i_total=250, trigger → 100, 100, then done with o_residue=50; with i_coin_empty=111b → zero coins, o_residue=250.
4. WAIT_CYCLES=4, i_total=100, no activity → o_wait_time 4→0 over 4 cycles; next cycle enters DISPENSE; coin 001b emitted.
5. i_activity pulsed at timer=1 → timer reloads to WAIT_CYCLES, no return. Trigger with i_total=0 → o_done pulse next cycle, no coins, o_residue=0.
6. Assert reset_n=0 mid-DISPENSE after the first coin → all outputs 0 immediately. After release: IDLE, timer=WAIT_CYCLES, no coins.
